// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for an in-order F/D/X/M/W core. It tracks the
//   valid/rd/wen state of the X, M and W stages and the is_load flag of X.
//   From these it produces fetch/decode stall, decode flush and the X-stage
//   operand forwarding selects. It also keeps a saturating count of
//   decode-stall cycles.
//
//   Ports
//     clk_i, rst_i                 clock, asynchronous active-high reset
//     d_valid_i                    decode instruction valid
//     d_rs1_i / d_rs2_i            decode source register addresses
//     d_rs1_used_i / d_rs2_used_i  source is actually read
//     d_rd_i, d_wen_i, d_is_load_i decode destination, write enable, load flag
//     x_busy_i                     multi-cycle execute in progress
//     x_branch_taken_i             branch/jump resolved taken in X
//     stall_f_o, stall_d_o         hold fetch / decode (combinational)
//     flush_d_o                    kill decode instruction (combinational)
//     fwd1_sel_o, fwd2_sel_o       X operand source: 00 regfile, 01 M, 10 W
//     x_valid_o, m_valid_o, w_valid_o  stage valids
//     w_rd_o, w_wen_o              writeback address / enable
//     stall_cnt_o                  saturating decode-stall cycle count
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int FWD_EN     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  d_valid_i,
   input  logic [REG_ADDR_W-1:0] d_rs1_i,
   input  logic [REG_ADDR_W-1:0] d_rs2_i,
   input  logic                  d_rs1_used_i,
   input  logic                  d_rs2_used_i,
   input  logic [REG_ADDR_W-1:0] d_rd_i,
   input  logic                  d_wen_i,
   input  logic                  d_is_load_i,
   input  logic                  x_busy_i,
   input  logic                  x_branch_taken_i,
   output logic                  stall_f_o,
   output logic                  stall_d_o,
   output logic                  flush_d_o,
   output logic [1:0]            fwd1_sel_o,
   output logic [1:0]            fwd2_sel_o,
   output logic                  x_valid_o,
   output logic                  m_valid_o,
   output logic                  w_valid_o,
   output logic [REG_ADDR_W-1:0] w_rd_o,
   output logic                  w_wen_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   // X stage (_p0), M stage (_p1), W stage (_p2). The load flag is only
   // consulted in X, where a load result is not yet available.
   logic                  vld_p0, vld_p1, vld_p2;
   logic [REG_ADDR_W-1:0] rd_p0, rd_p1, rd_p2;
   logic                  wen_p0, wen_p1, wen_p2;
   logic                  ld_p0;
   logic [1:0]            fwd1_p0, fwd2_p0;
   logic [CNT_W-1:0]      cnt;

   // Register x0 is hardwired zero, so a write to it never creates a dependency.
   function automatic logic match(input logic [REG_ADDR_W-1:0] s,
                                  input logic                  used,
                                  input logic                  vld,
                                  input logic                  wen,
                                  input logic [REG_ADDR_W-1:0] rd);
      return used & vld & wen & (rd == s) & (s != '0);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // The producer now in X will be in M when the consumer reaches X, hence 01.
   // A producer now in M will be in W, hence 10. The newer stage wins.
   function automatic logic [1:0] fwd_pick(input logic hit_x, input logic hit_m);
      if (hit_x)      return 2'b01;
      else if (hit_m) return 2'b10;
      else            return 2'b00;
   endfunction

   logic rs1_x, rs2_x, rs1_m, rs2_m;
   logic load_use, raw, branch;

   always_comb begin
      rs1_x    = match(d_rs1_i, d_rs1_used_i, vld_p0, wen_p0, rd_p0);
      rs2_x    = match(d_rs2_i, d_rs2_used_i, vld_p0, wen_p0, rd_p0);
      rs1_m    = match(d_rs1_i, d_rs1_used_i, vld_p1, wen_p1, rd_p1);
      rs2_m    = match(d_rs2_i, d_rs2_used_i, vld_p1, wen_p1, rd_p1);
      load_use = d_valid_i & ld_p0 & (rs1_x | rs2_x);
      // Without forwarding, any in-flight producer in X or M must drain;
      // W is covered by regfile write-through.
      raw      = (FWD_EN != 0) ? load_use
                               : (d_valid_i & (rs1_x | rs2_x | rs1_m | rs2_m));
      branch   = x_branch_taken_i & vld_p0 & ~x_busy_i;
   end

   // Priority: busy > branch > hazard. Outputs are forced low during reset.
   always_comb begin
      stall_f_o = 1'b0;
      stall_d_o = 1'b0;
      flush_d_o = 1'b0;
      if (!rst_i) begin
         if (x_busy_i) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
         end else if (branch) begin
            flush_d_o = 1'b1;
         end else if (raw) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_p0  <= 1'b0;
         rd_p0   <= '0;
         wen_p0  <= 1'b0;
         ld_p0   <= 1'b0;
         fwd1_p0 <= 2'b00;
         fwd2_p0 <= 2'b00;
         vld_p1  <= 1'b0;
         rd_p1   <= '0;
         wen_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         rd_p2   <= '0;
         wen_p2  <= 1'b0;
         cnt     <= '0;
      end else begin
         // ---- M -> W boundary: W always takes M ----
         vld_p2 <= vld_p1;
         rd_p2  <= rd_p1;
         wen_p2 <= wen_p1;

         if (x_busy_i) begin
            // ---- D -> X / X -> M boundary, busy: X holds, M takes a bubble ----
            vld_p1 <= 1'b0;
            wen_p1 <= 1'b0;
         end else begin
            // ---- X -> M boundary ----
            vld_p1 <= vld_p0;
            rd_p1  <= rd_p0;
            wen_p1 <= wen_p0;
            // ---- D -> X boundary ----
            if (branch || raw) begin
               vld_p0  <= 1'b0;
               wen_p0  <= 1'b0;
               ld_p0   <= 1'b0;
               fwd1_p0 <= 2'b00;
               fwd2_p0 <= 2'b00;
            end else begin
               vld_p0  <= d_valid_i;
               rd_p0   <= d_rd_i;
               wen_p0  <= d_wen_i;
               ld_p0   <= d_is_load_i;
               fwd1_p0 <= ((FWD_EN != 0) && d_valid_i) ? fwd_pick(rs1_x, rs1_m) : 2'b00;
               fwd2_p0 <= ((FWD_EN != 0) && d_valid_i) ? fwd_pick(rs2_x, rs2_m) : 2'b00;
            end
         end

         if (stall_d_o)
            cnt <= sat_inc(cnt);
      end
   end

   assign fwd1_sel_o  = fwd1_p0;
   assign fwd2_sel_o  = fwd2_p0;
   assign x_valid_o   = vld_p0;
   assign m_valid_o   = vld_p1;
   assign w_valid_o   = vld_p2;
   assign w_rd_o      = rd_p2;
   assign w_wen_o     = vld_p2 & wen_p2 & (rd_p2 != '0);
   assign stall_cnt_o = cnt;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter FWD_EN, default 1; 1 = forwarding, 0 = stall-only RAW resolution.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have ports:
  - clk_i  in  1  single clock; all state on rising edge.
  - rst_i  in  1  asynchronous, active-high reset.
  - d_valid_i  in  1  decode-stage instruction valid.
  - d_rs1_i, d_rs2_i  in  REG_ADDR_W  decode source registers.
  - d_rs1_used_i, d_rs2_used_i  in  1  source actually read.
  - d_rd_i  in  REG_ADDR_W  decode destination.
  - d_wen_i  in  1  decode instruction writes rd.
  - d_is_load_i  in  1  decode instruction is a load.
  - x_busy_i  in  1  multi-cycle execute in progress.
  - x_branch_taken_i  in  1  branch/jump resolved taken in X.
  - stall_f_o, stall_d_o  out  1  hold fetch / decode.
  - flush_d_o  out  1  kill decode instruction.
  - fwd1_sel_o, fwd2_sel_o  out  2  X operand source: 00 regfile, 01 M result, 10 W result.
  - x_valid_o, m_valid_o, w_valid_o  out  1  stage valid.
  - w_rd_o  out  REG_ADDR_W  writeback address.
  - w_wen_o  out  1  writeback enable (w_valid and wen and rd!=0).
  - stall_cnt_o  out  CNT_W  saturating stall-cycle count.

Function
REQ-005 SHALL track per stage X, M, W: valid, rd, wen, is_load.
REQ-006 Match(s, stage) SHALL be true only when s_used, stage valid, stage wen, stage rd == s and s != 0.
REQ-007 Load-use hazard SHALL be d_valid_i and Match(rs1 or rs2, X) with X is_load.
REQ-008 If FWD_EN=0, RAW hazard SHALL be d_valid_i and Match(rs1 or rs2, X or M); W is covered by regfile write-through.
REQ-009 If FWD_EN=1, RAW hazard SHALL equal load-use hazard.
REQ-010 Branch SHALL mean x_branch_taken_i and x_valid_o and not x_busy_i.
REQ-011 Priority SHALL be busy > branch > hazard > normal advance.
REQ-012 Busy SHALL force stall_f_o=stall_d_o=1; X holds; M gets bubble; W <= M.
REQ-013 Branch SHALL force flush_d_o=1, stall_f_o=stall_d_o=0; X gets bubble; M <= X; W <= M.
REQ-014 Hazard SHALL force stall_f_o=stall_d_o=1; X gets bubble; M <= X; W <= M.
REQ-015 Normal SHALL load X from d_* fields with valid = d_valid_i; M <= X; W <= M.
REQ-016 stall and flush outputs SHALL be combinational from current state and inputs (zero-cycle latency).
REQ-017 On a D->X load with FWD_EN=1, fwd sel SHALL register 01 if Match(s, X), else 10 if Match(s, M), else 00; the newer stage wins.
REQ-018 fwd sel SHALL hold while X holds under busy, register 00 on any bubble, and be constant 00 when FWD_EN=0.
REQ-019 stall_cnt_o SHALL increment each cycle stall_d_o=1 and saturate at all-ones.
REQ-020 A hazard with d_valid_i=0 SHALL NOT stall.
REQ-021 A branch coincident with a load-use hazard SHALL flush without stall.
REQ-022 Branch input SHALL be ignored while x_busy_i=1 and honoured on the first non-busy cycle.

Reset
REQ-023 rst_i=1 SHALL immediately clear all stage valids, rd, wen, is_load, fwd sels and stall_cnt_o.
REQ-024 During reset all outputs SHALL be 0.
REQ-025 Reset mid-stall or mid-busy SHALL discard all in-flight state; first post-reset cycle behaves as empty pipeline.

Verification
REQ-026 Load x5 into D, next cycle add using rs1=x5 -> stall_d_o=1 for exactly 1 cycle; then fwd1_sel_o=10 with the add in X; stall_cnt_o=1.
REQ-027 FWD_EN=1, back-to-back add x3 then sub using rs2=x3 -> no stall; fwd2_sel_o=01; with one independent instruction between -> fwd2_sel_o=10.
REQ-028 FWD_EN=0, same add/sub pair -> stall_d_o=1 for 2 cycles; fwd sels stay 00.
REQ-029 Load-use hazard coincident with x_branch_taken_i=1 -> flush_d_o=1, stall_d_o=0, x_valid_o=0 next cycle.
REQ-030 x_busy_i=1 for 3 cycles with branch asserted -> 3 stall cycles, m_valid_o=0 in each, flush_d_o on 4th cycle; rd=x0 writer never matches; rst_i pulse mid-busy -> all valids 0.
